// File: rtl/alt_mem_ddrx_wdata_addr_alloc.sv
// rtl/alt_mem_ddrx_wdata_addr_alloc.sv - write-data buffer address allocator with dataid FIFO
module alt_mem_ddrx_wdata_addr_alloc #(
    parameter int CFG_BUFFER_ADDR_WIDTH      = 6,
    parameter int CFG_INT_SIZE_WIDTH         = 4,
    parameter int CFG_DATAID_FIFO_ADDR_WIDTH = 2
) (
    input  logic                             ctl_clk,
    input  logic                             ctl_reset_n,
    input  logic                             cmd_valid,
    input  logic [CFG_INT_SIZE_WIDTH-1:0]    cmd_size,
    output logic                             cmd_ready,
    input  logic                             wdata_valid,
    output logic                             wdata_ready,
    output logic                             writeif_valid,
    output logic [CFG_BUFFER_ADDR_WIDTH-1:0] writeif_address,
    output logic                             writeif_address_blocked,
    input  logic                             writeif_ready,
    output logic                             dataid_valid,
    output logic [CFG_BUFFER_ADDR_WIDTH-1:0] dataid_address,
    output logic [CFG_INT_SIZE_WIDTH-1:0]    dataid_size,
    input  logic                             dataid_ready,
    output logic                             err_zero_size
);

    localparam int FIFO_DEPTH = 1 << CFG_DATAID_FIFO_ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                                  state;
    state_t                                  state_nxt;

    logic [CFG_BUFFER_ADDR_WIDTH-1:0]        wr_ptr;
    logic [CFG_BUFFER_ADDR_WIDTH-1:0]        start_addr;
    logic [CFG_INT_SIZE_WIDTH-1:0]           beat_cnt;
    logic [CFG_INT_SIZE_WIDTH-1:0]           burst_size;

    logic [CFG_BUFFER_ADDR_WIDTH-1:0]        fifo_addr_mem [FIFO_DEPTH];
    logic [CFG_INT_SIZE_WIDTH-1:0]           fifo_size_mem [FIFO_DEPTH];
    logic [CFG_DATAID_FIFO_ADDR_WIDTH-1:0]   fifo_wr_ptr;
    logic [CFG_DATAID_FIFO_ADDR_WIDTH-1:0]   fifo_rd_ptr;
    logic [CFG_DATAID_FIFO_ADDR_WIDTH:0]     fifo_count;

    logic                                    cmd_accept;
    logic                                    cmd_is_zero;
    logic                                    beat_accept;
    logic                                    last_beat;
    logic                                    fifo_push;
    logic                                    fifo_pop;

    // Count never exceeds depth, so its MSB alone marks a full FIFO.
    assign cmd_ready               = (state == IDLE) & ~fifo_count[CFG_DATAID_FIFO_ADDR_WIDTH];
    // Blocking depends on registered state only to keep the buffer-manager handshake loop-free.
    assign writeif_address_blocked = (state != BURST);
    assign writeif_valid           = wdata_valid & (state == BURST);
    assign wdata_ready             = writeif_ready & (state == BURST);
    assign writeif_address         = wr_ptr;

    assign cmd_accept  = cmd_valid & cmd_ready;
    assign cmd_is_zero = (cmd_size == '0);
    assign beat_accept = writeif_valid & writeif_ready;
    assign last_beat   = beat_accept & (beat_cnt == CFG_INT_SIZE_WIDTH'(1));
    assign fifo_push   = last_beat;
    assign fifo_pop    = dataid_valid & dataid_ready;

    assign dataid_valid   = (fifo_count != '0);
    assign dataid_address = fifo_addr_mem[fifo_rd_ptr];
    assign dataid_size    = fifo_size_mem[fifo_rd_ptr];

    // State register.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start a burst on a non-empty command, finish on its last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_accept && !cmd_is_zero) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture burst start and length when a command is taken.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            start_addr <= '0;
            burst_size <= '0;
        end else if (cmd_accept && !cmd_is_zero) begin
            start_addr <= wr_ptr;
            burst_size <= cmd_size;
        end
    end

    // Beat counter: loaded by the command, decremented per accepted beat.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            beat_cnt <= '0;
        end else if (cmd_accept && !cmd_is_zero) begin
            beat_cnt <= cmd_size;
        end else if (beat_accept) begin
            beat_cnt <= beat_cnt - CFG_INT_SIZE_WIDTH'(1);
        end
    end

    // Write pointer advances one slot per accepted beat and wraps naturally.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            wr_ptr <= '0;
        end else if (beat_accept) begin
            wr_ptr <= wr_ptr + CFG_BUFFER_ADDR_WIDTH'(1);
        end
    end

    // Sticky error for zero-length commands, which are otherwise dropped.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            err_zero_size <= 1'b0;
        end else if (cmd_accept && cmd_is_zero) begin
            err_zero_size <= 1'b1;
        end
    end

    // Dataid FIFO storage: one record per completed burst.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_mem[i] <= '0;
                fifo_size_mem[i] <= '0;
            end
        end else if (fifo_push) begin
            fifo_addr_mem[fifo_wr_ptr] <= start_addr;
            fifo_size_mem[fifo_wr_ptr] <= burst_size;
        end
    end

    // Dataid FIFO pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr <= fifo_wr_ptr + CFG_DATAID_FIFO_ADDR_WIDTH'(1);
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + CFG_DATAID_FIFO_ADDR_WIDTH'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + (CFG_DATAID_FIFO_ADDR_WIDTH+1)'(1);
                2'b01:   fifo_count <= fifo_count - (CFG_DATAID_FIFO_ADDR_WIDTH+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_alt_mem_ddrx_wdata_addr_alloc.sv
// tb/tb_alt_mem_ddrx_wdata_addr_alloc.sv - randomized self-checking bench for the write-data allocator
module tb_alt_mem_ddrx_wdata_addr_alloc;

    logic       ctl_clk;
    logic       ctl_reset_n;
    logic       cmd_valid;
    logic [3:0] cmd_size;
    logic       cmd_ready;
    logic       wdata_valid;
    logic       wdata_ready;
    logic       writeif_valid;
    logic [5:0] writeif_address;
    logic       writeif_address_blocked;
    logic       writeif_ready;
    logic       dataid_valid;
    logic [5:0] dataid_address;
    logic [3:0] dataid_size;
    logic       dataid_ready;
    logic       err_zero_size;

    int checks   = 0;
    int failures = 0;

    // Reference model: next free buffer slot, and the queue of completed bursts.
    int m_ptr;
    int q_addr[$];
    int q_size[$];
    bit m_err;

    alt_mem_ddrx_wdata_addr_alloc dut (
        .ctl_clk                 (ctl_clk),
        .ctl_reset_n             (ctl_reset_n),
        .cmd_valid               (cmd_valid),
        .cmd_size                (cmd_size),
        .cmd_ready               (cmd_ready),
        .wdata_valid             (wdata_valid),
        .wdata_ready             (wdata_ready),
        .writeif_valid           (writeif_valid),
        .writeif_address         (writeif_address),
        .writeif_address_blocked (writeif_address_blocked),
        .writeif_ready           (writeif_ready),
        .dataid_valid            (dataid_valid),
        .dataid_address          (dataid_address),
        .dataid_size             (dataid_size),
        .dataid_ready            (dataid_ready),
        .err_zero_size           (err_zero_size)
    );

    initial ctl_clk = 1'b0;
    always #5 ctl_clk = ~ctl_clk;

    task automatic tick();
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_err = 0;
        q_addr.delete();
        q_size.delete();
    endtask

    // Runs one command plus its beats. stall_at/stall_len inject writeif_ready=0 before beat stall_at;
    // rnd randomizes both wdata_valid and writeif_ready; pop_last pops the head on the final beat.
    task automatic do_burst(input int size, input int stall_at, input int stall_len,
                            input bit rnd, input bit pop_last);
        int  start;
        int  i;
        int  cyc;
        int  stalled;
        bit  acc;
        start   = m_ptr;
        i       = 0;
        cyc     = 0;
        stalled = 0;
        cmd_valid = 1'b1;
        cmd_size  = size[3:0];
        #1;
        checks++;
        if (cmd_ready !== (q_addr.size() < 4)) begin
            failures++;
            $display("FAIL burst_cmd_ready actual=%0b required=%0b", cmd_ready, (q_addr.size() < 4));
        end
        tick();
        cmd_valid = 1'b0;
        while (i < size && cyc < 200) begin
            cyc++;
            wdata_valid   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            writeif_ready = rnd ? ($urandom_range(0, 3) != 0) : !(i == stall_at && stalled < stall_len);
            dataid_ready  = pop_last && (i == size - 1) && wdata_valid && writeif_ready;
            #1;
            checks++;
            if (writeif_address !== 6'((start + i) % 64)) begin
                failures++;
                $display("FAIL beat_address actual=%0d required=%0d", writeif_address, (start + i) % 64);
            end
            checks++;
            if (wdata_ready !== writeif_ready) begin
                failures++;
                $display("FAIL beat_wdata_ready actual=%0b required=%0b", wdata_ready, writeif_ready);
            end
            checks++;
            if (writeif_address_blocked !== 1'b0 || writeif_valid !== wdata_valid) begin
                failures++;
                $display("FAIL beat_blocked_valid actual=%0b/%0b required=0/%0b",
                         writeif_address_blocked, writeif_valid, wdata_valid);
            end
            if (!writeif_ready) stalled++;
            acc = wdata_valid && writeif_ready;
            tick();
            if (acc) i++;
        end
        wdata_valid   = 1'b0;
        writeif_ready = 1'b1;
        dataid_ready  = 1'b0;
        checks++;
        if (i != size) begin
            failures++;
            $display("FAIL burst_timeout actual=%0d required=%0d", i, size);
        end
        if (pop_last && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_size.pop_front());
        end
        q_addr.push_back(start);
        q_size.push_back(size);
        m_ptr = (start + size) % 64;
        checks++;
        if (writeif_address_blocked !== 1'b1 || writeif_address !== 6'(m_ptr)) begin
            failures++;
            $display("FAIL burst_end actual=%0b/%0d required=1/%0d",
                     writeif_address_blocked, writeif_address, m_ptr);
        end
        checks++;
        if (dataid_valid !== 1'b1 || dataid_address !== 6'(q_addr[0]) || dataid_size !== 4'(q_size[0])) begin
            failures++;
            $display("FAIL burst_head actual=%0b/%0d/%0d required=1/%0d/%0d",
                     dataid_valid, dataid_address, dataid_size, q_addr[0], q_size[0]);
        end
    endtask

    // Pops every queued record, checking order and contents.
    task automatic drain();
        while (q_addr.size() > 0) begin
            checks++;
            if (dataid_valid !== 1'b1 || dataid_address !== 6'(q_addr[0]) || dataid_size !== 4'(q_size[0])) begin
                failures++;
                $display("FAIL drain_head actual=%0b/%0d/%0d required=1/%0d/%0d",
                         dataid_valid, dataid_address, dataid_size, q_addr[0], q_size[0]);
            end
            dataid_ready = 1'b1;
            tick();
            dataid_ready = 1'b0;
            void'(q_addr.pop_front());
            void'(q_size.pop_front());
        end
        checks++;
        if (dataid_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty actual=%0b required=0", dataid_valid);
        end
    endtask

    task automatic test_reset();
        ctl_reset_n = 1'b0;
        repeat (3) tick();
        ctl_reset_n = 1'b1;
        tick();
        model_reset();
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready actual=%0b required=1", cmd_ready); end
        checks++;
        if (writeif_address_blocked !== 1'b1) begin failures++; $display("FAIL reset_blocked actual=%0b required=1", writeif_address_blocked); end
        checks++;
        if (dataid_valid !== 1'b0) begin failures++; $display("FAIL reset_dataid_valid actual=%0b required=0", dataid_valid); end
        checks++;
        if (wdata_ready !== 1'b0) begin failures++; $display("FAIL reset_wdata_ready actual=%0b required=0", wdata_ready); end
        checks++;
        if (err_zero_size !== 1'b0) begin failures++; $display("FAIL reset_err actual=%0b required=0", err_zero_size); end
        checks++;
        if (writeif_address !== 6'd0 || writeif_valid !== 1'b0) begin
            failures++; $display("FAIL reset_wif actual=%0d/%0b required=0/0", writeif_address, writeif_valid);
        end
    endtask

    task automatic test_basic();
        do_burst(4, -1, 0, 1'b0, 1'b0);
        checks++;
        if (dataid_address !== 6'd0 || dataid_size !== 4'd4 || writeif_address !== 6'd4 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_result actual=%0d/%0d/%0d/%0b required=0/4/4/1",
                     dataid_address, dataid_size, writeif_address, cmd_ready);
        end
        drain();
    endtask

    task automatic test_wrap();
        // 4 + 15 + 15 + 15 + 13 = 62
        do_burst(15, -1, 0, 1'b0, 1'b0); drain();
        do_burst(15, -1, 0, 1'b0, 1'b0); drain();
        do_burst(15, -1, 0, 1'b0, 1'b0); drain();
        do_burst(13, -1, 0, 1'b0, 1'b0); drain();
        checks++;
        if (writeif_address !== 6'd62) begin failures++; $display("FAIL wrap_preload actual=%0d required=62", writeif_address); end
        do_burst(4, -1, 0, 1'b0, 1'b0);
        checks++;
        if (dataid_address !== 6'd62 || writeif_address !== 6'd2) begin
            failures++; $display("FAIL wrap_result actual=%0d/%0d required=62/2", dataid_address, writeif_address);
        end
        drain();
    endtask

    task automatic test_backpressure();
        do_burst(6, 2, 3, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_fifo_full();
        for (int k = 0; k < 4; k++) do_burst(1, -1, 0, 1'b0, 1'b0);
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_cmd_ready actual=%0b required=0", cmd_ready); end
        // A command offered while full must be ignored.
        cmd_valid = 1'b1;
        cmd_size  = 4'd3;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (writeif_address_blocked !== 1'b1 || dataid_address !== 6'(q_addr[0])) begin
            failures++; $display("FAIL full_ignored actual=%0b/%0d required=1/%0d",
                                 writeif_address_blocked, dataid_address, q_addr[0]);
        end
        dataid_ready = 1'b1;
        tick();
        dataid_ready = 1'b0;
        void'(q_addr.pop_front());
        void'(q_size.pop_front());
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL full_pop_cmd_ready actual=%0b required=1", cmd_ready); end
        // Push and pop on the same edge: occupancy stays at three.
        do_burst(2, -1, 0, 1'b0, 1'b1);
        checks++;
        if (cmd_ready !== 1'b1 || q_addr.size() != 3) begin
            failures++; $display("FAIL pushpop_count actual=%0b required=1", cmd_ready);
        end
        do_burst(1, -1, 0, 1'b0, 1'b0);
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL pushpop_full actual=%0b required=0", cmd_ready); end
        drain();
    endtask

    task automatic test_zero_size();
        cmd_valid = 1'b1;
        cmd_size  = 4'd0;
        tick();
        cmd_valid = 1'b0;
        m_err = 1;
        wdata_valid = 1'b1;
        #1;
        checks++;
        if (err_zero_size !== 1'b1 || writeif_address_blocked !== 1'b1 || dataid_valid !== 1'b0 ||
            wdata_ready !== 1'b0 || writeif_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_size actual=%0b/%0b/%0b/%0b/%0b required=1/1/0/0/0", err_zero_size,
                     writeif_address_blocked, dataid_valid, wdata_ready, writeif_valid);
        end
        tick();
        wdata_valid = 1'b0;
        checks++;
        if (writeif_address !== 6'(m_ptr)) begin
            failures++; $display("FAIL idle_wdata_ptr actual=%0d required=%0d", writeif_address, m_ptr);
        end
        do_burst(3, -1, 0, 1'b0, 1'b0);
        checks++;
        if (err_zero_size !== m_err) begin failures++; $display("FAIL zero_sticky actual=%0b required=%0b", err_zero_size, m_err); end
        drain();
    endtask

    task automatic test_reset_mid_burst();
        cmd_valid = 1'b1;
        cmd_size  = 4'd4;
        tick();
        cmd_valid     = 1'b0;
        wdata_valid   = 1'b1;
        writeif_ready = 1'b1;
        tick();
        tick();
        #2;
        ctl_reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (writeif_address_blocked !== 1'b1 || dataid_valid !== 1'b0 || writeif_address !== 6'd0 ||
            err_zero_size !== 1'b0) begin
            failures++;
            $display("FAIL async_reset actual=%0b/%0b/%0d/%0b required=1/0/0/0", writeif_address_blocked,
                     dataid_valid, writeif_address, err_zero_size);
        end
        wdata_valid = 1'b0;
        tick();
        ctl_reset_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || dataid_valid !== 1'b0) begin
            failures++; $display("FAIL post_reset actual=%0b/%0b required=1/0", cmd_ready, dataid_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            if (q_addr.size() == 4 || (q_addr.size() > 0 && $urandom_range(0, 1) == 1)) begin
                checks++;
                if (dataid_address !== 6'(q_addr[0]) || dataid_size !== 4'(q_size[0])) begin
                    failures++; $display("FAIL random_head actual=%0d/%0d required=%0d/%0d",
                                         dataid_address, dataid_size, q_addr[0], q_size[0]);
                end
                dataid_ready = 1'b1;
                tick();
                dataid_ready = 1'b0;
                void'(q_addr.pop_front());
                void'(q_size.pop_front());
            end
            do_burst(int'($urandom_range(1, 15)), -1, 0, 1'b1, 1'($urandom_range(0, 1)));
        end
        drain();
    endtask

    initial begin
        ctl_reset_n   = 1'b0;
        cmd_valid     = 1'b0;
        cmd_size      = 4'd0;
        wdata_valid   = 1'b0;
        writeif_ready = 1'b1;
        dataid_ready  = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_fifo_full();
        test_zero_size();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
